// File: rtl/qarma_mc_arbiter_if.sv
// Request/response bundle between two requesters and the QARMA multicycle arbiter.
// master: requester/consumer side, slave: the arbiter.
interface qarma_mc_arbiter_if;
    logic         req0_valid;
    logic         req0_ready;
    logic         req0_enc;
    logic [127:0] req0_k0;
    logic [127:0] req0_k1;
    logic [127:0] req0_data;
    logic [127:0] req0_t0;
    logic [127:0] req0_t1;

    logic         req1_valid;
    logic         req1_ready;
    logic         req1_enc;
    logic [127:0] req1_k0;
    logic [127:0] req1_k1;
    logic [127:0] req1_data;
    logic [127:0] req1_t0;
    logic [127:0] req1_t1;

    logic         rsp0_valid;
    logic         rsp1_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         busy;

    modport master (
        output req0_valid, req0_enc, req0_k0, req0_k1, req0_data, req0_t0, req0_t1,
        output req1_valid, req1_enc, req1_k0, req1_k1, req1_data, req1_t0, req1_t1,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
    );

    modport slave (
        input  req0_valid, req0_enc, req0_k0, req0_k1, req0_data, req0_t0, req0_t1,
        input  req1_valid, req1_enc, req1_k0, req1_k1, req1_data, req1_t0, req1_t1,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
    );
endinterface

// File: rtl/qarma_top.sv
// Combinational 128-bit tweakable block cipher core with the qarma_top port list.
// Compact QARMA-style substitution/permutation network (13 rounds, whitening,
// tweak-dependent round keys) standing in for the QARMAv2-128 core so the
// arbiter can be elaborated and simulated; enc=0 computes the exact inverse.
module qarma_top (
    input  logic         enc,
    input  logic [127:0] K0,
    input  logic [127:0] K1,
    input  logic [127:0] P,
    input  logic [127:0] T0,
    input  logic [127:0] T1,
    output logic [127:0] C
);
    localparam int ROUNDS = 13;
    // Nibble n of the table holds S[n].
    localparam logic [63:0]  SBOX     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0]  SBOX_INV = 64'hA970_364B_D21C_8FE5;
    localparam logic [127:0] RC       = 128'h243F6A8885A308D313198A2E03707344;

    function automatic logic [127:0] sub_cells(input logic [127:0] s, input logic [63:0] tbl);
        logic [127:0] o;
        logic [3:0]   n;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            n            = s[4*i +: 4];
            o[4*i +: 4]  = tbl[{n, 2'b00} +: 4];
        end
        return o;
    endfunction

    // Bit i moves to (32*i) mod 127; bit 127 is fixed. 32*4 = 1 mod 127 gives the inverse.
    function automatic logic [127:0] perm_fwd(input logic [127:0] s);
        logic [127:0] o;
        int           j;
        o      = '0;
        o[127] = s[127];
        for (int i = 0; i < 127; i++) begin
            j           = (i * 32) % 127;
            o[j[6:0]]   = s[i];
        end
        return o;
    endfunction

    function automatic logic [127:0] perm_inv(input logic [127:0] s);
        logic [127:0] o;
        int           j;
        o      = '0;
        o[127] = s[127];
        for (int i = 0; i < 127; i++) begin
            j    = (i * 32) % 127;
            o[i] = s[j[6:0]];
        end
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k0, input logic [127:0] k1,
                                               input logic [127:0] t0, input logic [127:0] t1,
                                               input int r);
        logic [127:0] rot;
        rot = (r == 0) ? k1 : ((k1 << r) | (k1 >> (128 - r)));
        return k0 ^ rot ^ (r[0] ? t1 : t0) ^ RC ^ {120'd0, r[7:0]};
    endfunction

    logic [127:0] s;

    // Unrolled cipher datapath; decryption walks the rounds backwards with inverse layers.
    always_comb begin
        s = P;
        if (enc) begin
            for (int r = 0; r < ROUNDS; r++) begin
                s = perm_fwd(sub_cells(s ^ round_key(K0, K1, T0, T1, r), SBOX));
            end
            s = s ^ round_key(K0, K1, T0, T1, ROUNDS);
        end else begin
            s = s ^ round_key(K0, K1, T0, T1, ROUNDS);
            for (int i = 0; i < ROUNDS; i++) begin
                s = sub_cells(perm_inv(s), SBOX_INV) ^ round_key(K0, K1, T0, T1, ROUNDS - 1 - i);
            end
        end
    end

    assign C = s;
endmodule

// File: rtl/qarma_mc_arbiter.sv
// Round-robin two-port arbiter and multicycle sequencer around one combinational
// qarma_top. Operands are registered at accept and held for WAIT_CYCLES clocks
// before the result is captured and offered on a valid/ready response channel.
module qarma_mc_arbiter #(
    parameter int unsigned WAIT_CYCLES = 4  // legal range 1..255
) (
    input logic               clk,
    input logic               rst_n,
    qarma_mc_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e       state;
    logic [7:0]   cnt;
    logic         owner;
    logic         last_grant;
    logic         busy_r;
    logic         rsp0_valid_r;
    logic         rsp1_valid_r;
    logic [127:0] rsp_data_r;

    // Operand registers: the only source of the core inputs (multicycle start points).
    logic         op_enc;
    logic [127:0] op_k0;
    logic [127:0] op_k1;
    logic [127:0] op_data;
    logic [127:0] op_t0;
    logic [127:0] op_t1;
    logic [127:0] core_c;

    logic         grant0;
    logic         grant1;

    // Grant in IDLE: a lone request wins; on a tie the port other than last_grant wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == StIdle) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.busy       = busy_r;

    qarma_top u_core (
        .enc (op_enc),
        .K0  (op_k0),
        .K1  (op_k1),
        .P   (op_data),
        .T0  (op_t0),
        .T1  (op_t1),
        .C   (core_c)
    );

    // Sequencer FSM with registered response, busy and operand state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            cnt          <= 8'd0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_data_r   <= '0;
            op_enc       <= 1'b0;
            op_k0        <= '0;
            op_k1        <= '0;
            op_data      <= '0;
            op_t0        <= '0;
            op_t1        <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // A grant implies the matching valid is high, so it is an accept.
                    if (grant0 || grant1) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        op_enc     <= grant1 ? bus.req1_enc  : bus.req0_enc;
                        op_k0      <= grant1 ? bus.req1_k0   : bus.req0_k0;
                        op_k1      <= grant1 ? bus.req1_k1   : bus.req0_k1;
                        op_data    <= grant1 ? bus.req1_data : bus.req0_data;
                        op_t0      <= grant1 ? bus.req1_t0   : bus.req0_t0;
                        op_t1      <= grant1 ? bus.req1_t1   : bus.req0_t1;
                        cnt        <= 8'(WAIT_CYCLES - 1);
                        busy_r     <= 1'b1;
                        state      <= StWait;
                    end
                end
                StWait: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        rsp_data_r   <= core_c;
                        rsp0_valid_r <= ~owner;
                        rsp1_valid_r <= owner;
                        state        <= StResp;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_qarma_mc_arbiter.sv
// Directed bench for qarma_mc_arbiter (WAIT_CYCLES = 4): reset, latency/data,
// round trip, arbitration, backpressure and reset during an operation.
module tb_qarma_mc_arbiter;
    localparam logic [127:0] KEY0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] PT   = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   checks;
    int   errors;

    logic [127:0] ct;
    logic         ref_enc;
    logic [127:0] ref_k0, ref_k1, ref_p, ref_t0, ref_t1, ref_c;

    qarma_mc_arbiter_if bus ();

    qarma_mc_arbiter #(.WAIT_CYCLES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Standalone reference core fed by the bench.
    qarma_top u_ref (
        .enc (ref_enc),
        .K0  (ref_k0),
        .K1  (ref_k1),
        .P   (ref_p),
        .T0  (ref_t0),
        .T1  (ref_t1),
        .C   (ref_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin errors++;
            $display("FAIL reset_rsp_valid got %b want 00", {bus.rsp0_valid, bus.rsp1_valid}); end
        checks++; if (bus.rsp_data !== 128'd0) begin errors++;
            $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++;
            $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL post_reset_busy got %b want 0", bus.busy); end
        bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++;
            $display("FAIL req1_only_ready got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        // Withdraw before the edge: a cancelled request must leave the arbiter idle.
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL cancel_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_latency();
        bus.req0_enc = 1'b1; bus.req0_k0 = KEY0; bus.req0_k1 = '0;
        bus.req0_data = PT;  bus.req0_t0 = '0;   bus.req0_t1 = '0;
        ref_enc = 1'b1; ref_k0 = KEY0; ref_k1 = '0; ref_p = PT; ref_t0 = '0; ref_t1 = '0;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++;
            $display("FAIL lat_ready got %b want 1", bus.req0_ready); end
        @(posedge clk); #1;  // accept edge E0
        bus.req0_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++;
            $display("FAIL lat_busy_rise got %b want 1", bus.busy); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++; if (bus.rsp0_valid !== (k == 4)) begin errors++;
                $display("FAIL lat_rsp0_valid_E0+%0d got %b want %b", k, bus.rsp0_valid, (k == 4)); end
        end
        checks++; if (bus.rsp_data !== ref_c) begin errors++;
            $display("FAIL lat_rsp_data got %h want %h", bus.rsp_data, ref_c); end
        checks++; if (bus.rsp1_valid !== 1'b0) begin errors++;
            $display("FAIL lat_rsp1_valid got %b want 0", bus.rsp1_valid); end
        ct = ref_c;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++; if ({bus.rsp0_valid, bus.busy} !== 2'b00) begin errors++;
            $display("FAIL lat_handshake got %b want 00", {bus.rsp0_valid, bus.busy}); end
    endtask

    task automatic test_round_trip();
        logic got;
        bus.req1_enc = 1'b0; bus.req1_k0 = KEY0; bus.req1_k1 = '0;
        bus.req1_data = ct;  bus.req1_t0 = '0;   bus.req1_t1 = '0;
        bus.req1_valid = 1'b1;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++;
            $display("FAIL rt_ready got %b want 1", bus.req1_ready); end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.rsp1_valid) got = 1'b1;
        end
        checks++; if (got !== 1'b1) begin errors++;
            $display("FAIL rt_timeout got %b want 1", got); end
        checks++; if (bus.rsp_data !== PT) begin errors++;
            $display("FAIL rt_data got %h want %h", bus.rsp_data, PT); end
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL rt_rsp0_valid got %b want 0", bus.rsp0_valid); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL rt_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_arbitration();
        int   n_acc;
        int   viol;
        logic bench_owner;
        logic acc_port [4];
        int   acc_edge [4];
        logic done;
        bus.req0_enc = 1'b1; bus.req0_data = 128'h1111;
        bus.req1_enc = 1'b1; bus.req1_data = 128'h2222;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        n_acc = 0; viol = 0; bench_owner = 1'b0;
        for (int i = 0; i < 4; i++) begin acc_port[i] = 1'bx; acc_edge[i] = 0; end
        for (int i = 0; i < 80 && n_acc < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) viol++;
            if (bus.rsp1_valid && !bench_owner) viol++;
            if (bus.rsp0_valid && bench_owner) viol++;
            if (bus.req0_ready || bus.req1_ready) begin
                acc_port[n_acc] = bus.req1_ready;
                acc_edge[n_acc] = edge_cnt + 1;
                bench_owner     = bus.req1_ready;
                n_acc++;
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        checks++; if (n_acc !== 4) begin errors++;
            $display("FAIL arb_accepts got %0d want 4", n_acc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (acc_port[i] !== logic'(i % 2)) begin errors++;
                $display("FAIL arb_grant%0d got %b want %0d", i, acc_port[i], i % 2); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (acc_edge[i] - acc_edge[i-1] !== 6) begin errors++;
                $display("FAIL arb_spacing%0d got %0d want 6", i, acc_edge[i] - acc_edge[i-1]); end
        end
        checks++; if (viol !== 0) begin errors++;
            $display("FAIL arb_exclusive got %0d violations want 0", viol); end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) done = 1'b1;
        end
        bus.rsp_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL arb_drain got %b want 1", done); end
    endtask

    task automatic test_backpressure();
        logic got;
        int   v_valid, v_data, v_ready;
        bus.req0_enc = 1'b1; bus.req0_k0 = 128'hA5A5; bus.req0_k1 = KEY0;
        bus.req0_data = 128'hDEADBEEF; bus.req0_t0 = 128'h7; bus.req0_t1 = 128'h9;
        ref_enc = 1'b1; ref_k0 = 128'hA5A5; ref_k1 = KEY0; ref_p = 128'hDEADBEEF;
        ref_t0 = 128'h7; ref_t1 = 128'h9;
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++;
            $display("FAIL bp_ready got %b want 1", bus.req0_ready); end
        @(posedge clk); #1;
        bus.req1_valid = 1'b1;  // both ports now pending
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.rsp0_valid) got = 1'b1;
        end
        checks++; if (got !== 1'b1) begin errors++;
            $display("FAIL bp_timeout got %b want 1", got); end
        v_valid = 0; v_data = 0; v_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) v_valid++;
            if (bus.rsp_data !== ref_c) v_data++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) v_ready++;
        end
        checks++; if (v_valid !== 0) begin errors++;
            $display("FAIL bp_valid_stable got %0d bad cycles want 0", v_valid); end
        checks++; if (v_data !== 0) begin errors++;
            $display("FAIL bp_data_stable got %0d bad cycles want 0", v_data); end
        checks++; if (v_ready !== 0) begin errors++;
            $display("FAIL bp_ready_low got %0d bad cycles want 0", v_ready); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++; if ({bus.busy, bus.rsp0_valid} !== 2'b00) begin errors++;
            $display("FAIL bp_release got %b want 00", {bus.busy, bus.rsp0_valid}); end
        // Back in IDLE with a tie; port 0 was last granted so port 1 is offered.
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++;
            $display("FAIL bp_idle_grant got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        checks++; if (bus.rsp_data !== ref_c) begin errors++;
            $display("FAIL bp_data_retained got %h want %h", bus.rsp_data, ref_c); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int viol;
        bus.req0_valid = 1'b1;
        @(posedge clk); #1;  // accept
        bus.req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin errors++;
            $display("FAIL rst_mid_flags got %b want 000",
                     {bus.busy, bus.rsp0_valid, bus.rsp1_valid}); end
        checks++; if (bus.rsp_data !== 128'd0) begin errors++;
            $display("FAIL rst_mid_data got %h want 0", bus.rsp_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) viol++;
        end
        checks++; if (viol !== 0) begin errors++;
            $display("FAIL rst_mid_no_rsp got %0d bad cycles want 0", viol); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++;
            $display("FAIL rst_mid_tie got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_enc = 1'b0; bus.req0_k0 = '0; bus.req0_k1 = '0;
        bus.req0_data = '0; bus.req0_t0 = '0; bus.req0_t1 = '0;
        bus.req1_valid = 1'b0; bus.req1_enc = 1'b0; bus.req1_k0 = '0; bus.req1_k1 = '0;
        bus.req1_data = '0; bus.req1_t0 = '0; bus.req1_t1 = '0;
        bus.rsp_ready = 1'b0;
        ref_enc = 1'b0; ref_k0 = '0; ref_k1 = '0; ref_p = '0; ref_t0 = '0; ref_t1 = '0;
        ct = '0;
        test_reset();
        test_latency();
        test_round_trip();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qarma_mc_arbiter.md
# qarma_mc_arbiter

Two-requester arbiter and multicycle sequencer wrapped around one shared combinational `qarma_top` core (QARMAv2, 128-bit, 13 rounds). It registers each request's operands, holds them stable while the core's long combinational path settles for `WAIT_CYCLES` clocks, captures the result, and returns it to the granting requester over a valid/ready response channel. Round-robin arbitration grants the core to one request at a time.

## Interface
- `WAIT_CYCLES`, default 4: clocks between operand launch and result capture. Legal range 1..255. Multicycle timing constraint from the operand registers to the result register equals `WAIT_CYCLES`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending on port N.
- `req0_ready`, `req1_ready`  out  1  request on port N is accepted this cycle.
- `reqN_enc`  in  1  1 = encrypt, 0 = decrypt (N = 0, 1).
- `reqN_k0`, `reqN_k1`  in  128  key halves K0, K1.
- `reqN_data`  in  128  plaintext (enc) or ciphertext (dec).
- `reqN_t0`, `reqN_t1`  in  128  tweak halves T0, T1.
- `rsp0_valid`, `rsp1_valid`  out  1  result available for requester N; never both high.
- `rsp_ready`  in  1  the consumer of the active response accepts it.
- `rsp_data`  out  128  result of the core (C).
- `busy`  out  1  high in every state except IDLE.

## Operation
- Instantiates `qarma_top` once. The core inputs `enc`, `K0`, `K1`, `P`, `T0`, `T1` are driven only from operand registers (641 bits).
- FSM states: IDLE, WAIT, RESP.
- In IDLE, the grant is chosen combinationally:
  - If exactly one `reqN_valid` is high, that port is granted.
  - If both are high, the port other than `last_grant` is granted.
  - `reqN_ready = IDLE & reqN_valid & granted(N)`. At most one ready is high.
- Accept (valid & ready at an edge):
  - Load the operand registers from port N.
  - Record `owner = N` and set `last_grant = N`.
  - Load `cnt = WAIT_CYCLES-1` and go to WAIT.
- WAIT:
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, capture the core output into the `rsp_data` register, assert `rspN_valid` for `owner`, and go to RESP.
  - Requests are ignored; both readys are low.
- RESP:
  - `rsp_data` and `rspN_valid` are held stable until `rsp_ready` is high at an edge.
  - At that edge, drop `rspN_valid` and go to IDLE. A new request is not accepted in the same edge.
- Operand registers are never updated outside the accept edge. The core inputs are therefore stable for all of WAIT and RESP.
- Requesters must hold `valid` and operands stable until ready. Dropping valid before ready is legal and simply cancels the request; no state changes.
- `rsp_data` retains its last value after handshake. It is only meaningful while a `rspN_valid` is high.

## Timing
- Reset, asynchronous, any state including mid-WAIT or RESP:
  - State becomes IDLE, `cnt = 0`, `owner = 0`, `last_grant = 1` (port 0 wins the first tie).
  - Operand registers and `rsp_data` are cleared to 0.
  - `rsp0_valid = rsp1_valid = 0`, `busy = 0`. Readys follow the IDLE rule once `rst_n` deasserts.
  - An in-flight operation is discarded with no response.
- Latency: with accept at edge E0, `rspN_valid` rises after edge E0+`WAIT_CYCLES`.
- Minimum issue period, with `rsp_ready` held high: `WAIT_CYCLES`+2 clocks.
- `busy` rises after the accept edge and falls after the response handshake edge.
- `WAIT_CYCLES = 1`: WAIT lasts one clock, and capture happens on the first edge after accept.
- `req0_ready` and `req1_ready` are combinational from state, valids and `last_grant`. There is no combinational path from operand inputs to any output.

## Test plan
- Reset defaults: hold `rst_n` low, then release with no requests.
  - Expect all outputs 0, `busy = 0`.
  - Assert `req1_valid` only: `req1_ready = 1` in the same cycle.
- Latency and data, `WAIT_CYCLES = 4`: req0 encrypt with K0 = 0x0011..FF, K1 = 0, P = 0x0123456789ABCDEFFEDCBA9876543210, T0 = T1 = 0, accepted at edge 10.
  - `rsp0_valid` rises after edge 14.
  - `rsp_data` equals a standalone `qarma_top` driven with the same inputs.
- Round trip: submit the previous ciphertext as a decrypt with the same keys and tweak. Expect `rsp_data = 0x0123456789ABCDEFFEDCBA9876543210`.
- Arbitration: both valids held high continuously, `rsp_ready = 1`.
  - Grants alternate 0, 1, 0, 1.
  - Accept edges are spaced 6 clocks apart.
  - `rsp1_valid` is never high while `owner = 0`.
- Backpressure: hold `rsp_ready = 0` for 20 cycles in RESP.
  - `rsp0_valid` and `rsp_data` stay stable.
  - Both readys stay 0 despite pending requests.
  - Release: IDLE follows one cycle later.
- Reset mid-operation: assert `rst_n` low 2 cycles after accept.
  - Outputs clear immediately (asynchronous).
  - No response is ever produced for that request.
  - The next tie after release grants port 0.
